// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared timing constants and width helper for the key debouncer
//
// Purpose: default debounce/hold constants for a 50 MHz clock and a helper
// that returns the counter width needed to hold a given cycle count.
// Ports: none (package).
package key_pkg;

  localparam int STABLE_10MS_50M = 500000;
  localparam int HOLD_1S_50M     = 50000000;

  // Bits needed to represent the value 'cycles' (never less than 1).
  function automatic int cnt_width(input longint cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one debounced key channel with edge and long-press pulses
//
// Purpose: 2-FF synchroniser, stable-level filter, press/release pulses and a
// hold counter that produces long-press / auto-repeat pulses.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   sw_in    raw asynchronous key level
//   sw_out   debounced level
//   sw_rise  one-cycle pulse on accepted 0->1
//   sw_fall  one-cycle pulse on accepted 1->0
//   sw_long  one-cycle long-press / repeat pulse
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int STABLE_CYC = STABLE_10MS_50M,
  parameter int HOLD_W     = 26,
  parameter int HOLD_CYC   = HOLD_1S_50M,
  parameter int REPEAT_CYC = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic sw_out,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_long
);

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(STABLE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYC - 1);
  // Parking value one past the match point: stops further pulses until release.
  localparam logic [HOLD_W-1:0] HOLD_SAT    = HOLD_W'(HOLD_CYC);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYC - REPEAT_CYC);

  logic              sync1;
  logic              sync2;
  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      hcnt    <= '0;
      sw_out  <= 1'b0;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      sw_long <= 1'b0;
    end else begin
      sync1   <= sw_in;
      sync2   <= sync1;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      sw_long <= 1'b0;

      // Any agreement restarts the count, so bounce never accumulates.
      if (sync2 == sw_out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        sw_out  <= sync2;
        sw_rise <= sync2;
        sw_fall <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (HOLD_CYC == 0 || !sw_out) begin
        hcnt <= '0;
      end else if (hcnt == HOLD_LAST) begin
        sw_long <= 1'b1;
        hcnt    <= (REPEAT_CYC == 0) ? HOLD_SAT : HOLD_RELOAD;
      end else if (hcnt != HOLD_SAT) begin
        hcnt <= hcnt + HOLD_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_debounce_n.sv
// rtl/key_debounce_n.sv - N-channel key debouncer with edge and long-press events
//
// Purpose: replicates key_debounce_ch over N independent channels and checks
// parameter legality at elaboration.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   SW_IN    [N] raw asynchronous key levels
//   SW_OUT   [N] debounced levels
//   SW_RISE  [N] one-cycle accepted 0->1 pulses
//   SW_FALL  [N] one-cycle accepted 1->0 pulses
//   SW_LONG  [N] one-cycle long-press / repeat pulses
module key_debounce_n
  import key_pkg::*;
#(
  parameter int N          = 8,
  parameter int CNT_W      = 20,
  parameter int STABLE_CYC = STABLE_10MS_50M,
  parameter int HOLD_W     = 26,
  parameter int HOLD_CYC   = HOLD_1S_50M,
  parameter int REPEAT_CYC = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] SW_IN,
  output logic [N-1:0] SW_OUT,
  output logic [N-1:0] SW_RISE,
  output logic [N-1:0] SW_FALL,
  output logic [N-1:0] SW_LONG
);

  if (STABLE_CYC < 1 || cnt_width(STABLE_CYC) > CNT_W) begin : g_bad_stable
    $error("key_debounce_n: STABLE_CYC must be >= 1 and fit in CNT_W bits");
  end

  if (HOLD_CYC < 0 || cnt_width(HOLD_CYC) > HOLD_W) begin : g_bad_hold
    $error("key_debounce_n: HOLD_CYC must fit in HOLD_W bits");
  end

  if (REPEAT_CYC < 0 || REPEAT_CYC > HOLD_CYC) begin : g_bad_repeat
    $error("key_debounce_n: REPEAT_CYC must not exceed HOLD_CYC");
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_W      (CNT_W),
      .STABLE_CYC (STABLE_CYC),
      .HOLD_W     (HOLD_W),
      .HOLD_CYC   (HOLD_CYC),
      .REPEAT_CYC (REPEAT_CYC)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .sw_in   (SW_IN[i]),
      .sw_out  (SW_OUT[i]),
      .sw_rise (SW_RISE[i]),
      .sw_fall (SW_FALL[i]),
      .sw_long (SW_LONG[i])
    );
  end

endmodule

// File: doc/key_debounce_n.md
# key_debounce_n

N-channel switch/key debouncer with edge and long-press event outputs. It replaces per-bit, fixed-width debounce instantiation with a single parametrised block. Each channel synchronises its raw input and filters it to a stable level. It also emits one-cycle press and release pulses, plus long-press and auto-repeat pulses. The block sits between the board switch/key pins and downstream control logic (counters, FSMs, display drivers).

## Interface
- `N`, 8: channel count.
- `CNT_W`, 20: debounce counter width.
- `STABLE_CYC`, 500000: consecutive cycles a new level must persist before it is accepted (10 ms at 50 MHz). Legal range is 1 ≤ STABLE_CYC < 2^CNT_W.
- `HOLD_W`, 26: hold counter width.
- `HOLD_CYC`, 50000000: cycles of continuous high stable level before SW_LONG fires. 0 disables long-press and repeat.
- `REPEAT_CYC`, 0: interval between repeat pulses after the first SW_LONG. 0 means a single SW_LONG per press.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `SW_IN` in N: raw asynchronous switch/key levels.
- `SW_OUT` out N: debounced level.
- `SW_RISE` out N: one-cycle pulse on accepted 0→1.
- `SW_FALL` out N: one-cycle pulse on accepted 1→0.
- `SW_LONG` out N: one-cycle long-press / repeat pulse.

## Operation
Each channel is independent; there is no cross-channel interaction.

- **Synchroniser:** 2-FF, sync1 → sync2. The filter only ever sees sync2.
- **Debounce counter `cnt`:**
  - Cleared on any cycle where sync2 == SW_OUT.
  - Otherwise increments.
  - On a cycle where sync2 != SW_OUT and cnt == STABLE_CYC-1: SW_OUT toggles on the next edge and cnt clears.
- **Glitches:** a disagreement shorter than STABLE_CYC cycles clears cnt and never reaches SW_OUT. Bounce that returns to the old level restarts the count from 0.
- **Edge pulses:** SW_RISE/SW_FALL are registered and asserted in the same cycle SW_OUT takes its new value. Each is high for exactly one cycle. They are never both high on one channel.
- **Hold counter `hcnt`:**
  - Runs only while SW_OUT == 1 and HOLD_CYC > 0; cleared whenever SW_OUT == 0.
  - When hcnt reaches HOLD_CYC-1: SW_LONG pulses once.
  - If REPEAT_CYC == 0: hcnt then saturates, giving no further pulses until release.
  - If REPEAT_CYC > 0: hcnt reloads to HOLD_CYC-REPEAT_CYC, so SW_LONG repeats every REPEAT_CYC cycles while held.
- **Release during hold:** clears hcnt with no SW_LONG. SW_FALL still fires normally.
- **Reset:**
  - sync1, sync2, SW_OUT, cnt, hcnt and all pulse outputs go to 0.
  - Reset mid-debounce or mid-hold abandons the count with no pulse.
  - If SW_IN is 1 through reset release, SW_OUT rises STABLE_CYC+2 cycles later with a SW_RISE pulse. This is required behaviour, not an error.

## Timing
- **Latency:** with SW_IN steady from edge k, SW_OUT and the edge pulse change after edge k+STABLE_CYC+1, i.e. STABLE_CYC+2 edges including synchronisation.
- **SW_LONG:** first pulse appears HOLD_CYC cycles after the SW_RISE cycle. Repeats follow at REPEAT_CYC spacing.
- **Outputs:** all are registered with no combinational path from SW_IN. Each output is a constant 0 during and in the cycle after reset.
- **Width rules:**
  - Counters compare with equality against the parameter minus 1.
  - HOLD_CYC < 2^HOLD_W is required.
  - REPEAT_CYC ≤ HOLD_CYC is required; the top level asserts this at elaboration.

## Structure
- Package `key_pkg`: default timing constants (STABLE_10MS_50M, HOLD_1S_50M) and a `clog2`-based width helper.
- Sub-module `key_debounce_ch`: one channel (synchroniser, cnt, hcnt, pulse regs), scalar ports.
- Top level: a generate loop over N plus parameter checks.

## Test plan
All scenarios use N=4, STABLE_CYC=4, HOLD_CYC=10, REPEAT_CYC=0 unless stated.

1. **Clean press.** SW_IN[0] 0→1 at cycle 10 and held → SW_OUT[0]=1 from cycle 16, SW_RISE[0] high in cycle 16 only. Other channels stay 0.
2. **Bounce.** SW_IN[1] pattern 1,0,1,1,0,1,1,1,1 → a single SW_RISE[1], 6 cycles after the final 0→1. No SW_FALL[1].
3. **Short glitch.** SW_IN[2]=1 for 3 cycles then 0 → SW_OUT[2] stays 0 and no pulses.
4. **Long press.** Hold SW_IN[3]=1 for 40 cycles → SW_LONG[3] exactly once, 10 cycles after SW_RISE[3]. Release gives SW_FALL[3].
5. **Repeat.** Same as test 4 with REPEAT_CYC=3 → SW_LONG[3] at +10, +13, +16, … until release, then no further pulses.
6. **Reset mid-operation.** Assert rst at cnt=2 with SW_IN=4'b1111 held → all outputs 0 during reset. After release, SW_OUT=4'hF exactly 6 cycles later with SW_RISE=4'hF for one cycle.
